// File: rtl/vend_dispense_arbiter.sv
// Round-robin owner of the shared goods chute and coin hopper.
// Sequences vend, per-coin payout with sensor confirm, ack/err return.
module vend_dispense_arbiter #(
  parameter int NREQ      = 4,
  parameter int MOTOR_CYC = 8,
  parameter int COIN_CYC  = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_goods,
  input  logic [4*NREQ-1:0] req_change,
  input  logic              coin_sense,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   err,
  output logic [2:0]        chute,
  output logic              hopper,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int M1 = (MOTOR_CYC > COIN_CYC) ? MOTOR_CYC : COIN_CYC;
  localparam int CMAX = (M1 > TIMEOUT) ? M1 : TIMEOUT;
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    VEND,
    PAY,
    SENSE,
    DONE,
    FAULT
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   win, win_n;
  logic [1:0]      goods, goods_n;
  logic [3:0]      coins, coins_n;
  logic [CW-1:0]   cnt, cnt_n;

  logic [NREQ-1:0] gnt_n, ack_n, err_n;
  logic [2:0]      chute_n;
  logic            hopper_n, busy_n;

  logic [IW-1:0]   pick, cand;
  logic            found;
  logic [1:0]      sel_goods;
  logic [3:0]      sel_change;

  // Round-robin search starting just above the last winner
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = ptr;
    for (int i = 0; i < NREQ; i++) begin
      cand = (cand == IW'(NREQ - 1)) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Mux out the owner's goods code and change amount
  always_comb begin
    sel_goods  = '0;
    sel_change = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        sel_goods  = req_goods[2*i +: 2];
        sel_change = req_change[4*i +: 4];
      end
    end
  end

  // Next state, datapath and registered-output values
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    win_n   = win;
    goods_n = goods;
    coins_n = coins;
    cnt_n   = cnt;
    gnt_n   = gnt;

    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          ptr_n   = pick;
          win_n   = pick;
          gnt_n   = NREQ'(1) << pick;
        end
      end
      GRANT: begin
        goods_n = sel_goods;
        coins_n = sel_change;
        cnt_n   = '0;
        if (sel_goods != 2'd0) state_n = VEND;
        else if (sel_change != 4'd0) state_n = PAY;
        else state_n = DONE;
      end
      VEND: begin
        if (cnt == CW'(MOTOR_CYC - 1)) begin
          cnt_n   = '0;
          state_n = (coins != 4'd0) ? PAY : DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PAY: begin
        if (cnt == CW'(COIN_CYC - 1)) begin
          cnt_n   = '0;
          state_n = SENSE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SENSE: begin
        if (coin_sense) begin
          coins_n = coins - 1'b1;
          cnt_n   = '0;
          state_n = (coins_n == 4'd0) ? DONE : PAY;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          cnt_n   = '0;
          state_n = FAULT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      FAULT: begin
        coins_n = '0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (state_n == IDLE) gnt_n = '0;

    ack_n = '0;
    err_n = '0;
    if (state_n == DONE)  ack_n = NREQ'(1) << win_n;
    if (state_n == FAULT) err_n = NREQ'(1) << win_n;

    chute_n = '0;
    if (state_n == VEND) begin
      unique case (goods_n)
        2'd1:    chute_n = 3'b001;
        2'd2:    chute_n = 3'b010;
        2'd3:    chute_n = 3'b100;
        default: chute_n = 3'b000;
      endcase
    end

    hopper_n = (state_n == PAY);
    busy_n   = (state_n != IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= IW'(NREQ - 1);
      win    <= '0;
      goods  <= '0;
      coins  <= '0;
      cnt    <= '0;
      gnt    <= '0;
      ack    <= '0;
      err    <= '0;
      chute  <= '0;
      hopper <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      win    <= win_n;
      goods  <= goods_n;
      coins  <= coins_n;
      cnt    <= cnt_n;
      gnt    <= gnt_n;
      ack    <= ack_n;
      err    <= err_n;
      chute  <= chute_n;
      hopper <= hopper_n;
      busy   <= busy_n;
    end
  end

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Directed bench for vend_dispense_arbiter.
// Cycle-indexed expectations per transaction.
module tb_vend_dispense_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] req_goods;
  logic [15:0] req_change;
  logic       coin_sense;
  logic [3:0] gnt, ack, err;
  logic [2:0] chute;
  logic       hopper, busy;

  int n_tests = 0;
  int n_fail  = 0;

  vend_dispense_arbiter #(
    .NREQ(4),
    .MOTOR_CYC(8),
    .COIN_CYC(4),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_goods(req_goods),
    .req_change(req_change),
    .coin_sense(coin_sense),
    .gnt(gnt),
    .ack(ack),
    .err(err),
    .chute(chute),
    .hopper(hopper),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int exp_ord[5];
  bit seen;

  initial begin
    rst = 1'b1;
    req = '0;
    req_goods = '0;
    req_change = '0;
    coin_sense = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_chute", chute, 0);
    chk("rst_hopper", hopper, 0);
    chk("rst_ackerr", {ack, err}, 0);
    rst = 1'b0;
    tick;

    // requester 0 vends goods 2, no change
    req = 4'b0001;
    req_goods[1:0] = 2'd2;
    for (int k = 1; k <= 11; k++) begin
      tick;
      if (k <= 9) chk($sformatf("t1_gnt_k%0d", k), gnt, 4'b0001);
      chk($sformatf("t1_chute_k%0d", k), chute,
          (k >= 2 && k <= 9) ? 3'b010 : 3'b000);
      chk($sformatf("t1_hop_k%0d", k), hopper, 0);
      chk($sformatf("t1_ack_k%0d", k), ack, (k == 10) ? 4'b0001 : 4'b0000);
      if (k == 10) req = '0;
    end
    chk("t1_gnt_end", gnt, 0);
    chk("t1_busy_end", busy, 0);

    // requester 1: two coins, sensor two cycles into each SENSE
    req_goods = '0;
    req = 4'b0010;
    req_change[7:4] = 4'd2;
    for (int k = 1; k <= 17; k++) begin
      tick;
      coin_sense = (k == 8 || k == 15);
      chk($sformatf("t2_hop_k%0d", k), hopper,
          ((k >= 2 && k <= 5) || (k >= 9 && k <= 12)) ? 1 : 0);
      chk($sformatf("t2_ack_k%0d", k), ack, (k == 16) ? 4'b0010 : 4'b0000);
      chk($sformatf("t2_chute_k%0d", k), chute, 0);
      if (k == 16) req = '0;
    end
    chk("t2_busy_end", busy, 0);

    // requester 3: stray sensor in IDLE/PAY, change edited mid-run
    req_change = '0;
    req = 4'b1000;
    req_change[15:12] = 4'd1;
    coin_sense = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick;
      coin_sense = (k == 3 || k == 7);
      if (k == 3) req_change[15:12] = 4'd5;
      chk($sformatf("t5_hop_k%0d", k), hopper,
          (k >= 2 && k <= 5) ? 1 : 0);
      chk($sformatf("t5_ack_k%0d", k), ack, (k == 8) ? 4'b1000 : 4'b0000);
      if (k == 8) req = '0;
    end
    chk("t5_busy_end", busy, 0);
    chk("t5_err", err, 0);

    // all four request at once; 0 re-raised while 3 is granted
    coin_sense = 1'b0;
    req_change = '0;
    req_goods = 8'b01_01_01_01;
    req = 4'b1111;
    exp_ord = '{0, 1, 2, 3, 0};
    for (int n = 0; n < 5; n++) begin
      seen = 1'b0;
      for (int w = 0; w < 30 && !seen; w++) begin
        tick;
        if (n == 3 && gnt == 4'b1000) req[0] = 1'b1;
        if (ack != 0) seen = 1'b1;
      end
      chk($sformatf("rr_ack_n%0d", n), ack, 4'b0001 << exp_ord[n]);
      for (int i = 0; i < 4; i++) if (ack[i]) req[i] = 1'b0;
      tick;
      chk($sformatf("rr_gap_n%0d", n), gnt, 0);
    end
    req = '0;
    tick;

    // requester 2: goods 3, one coin, sensor never fires
    req_goods = '0;
    req_goods[5:4] = 2'd3;
    req_change[11:8] = 4'd1;
    req = 4'b0100;
    for (int k = 1; k <= 31; k++) begin
      tick;
      if (k <= 29) chk($sformatf("t4_gnt_k%0d", k), gnt, 4'b0100);
      chk($sformatf("t4_chute_k%0d", k), chute,
          (k >= 2 && k <= 9) ? 3'b100 : 3'b000);
      chk($sformatf("t4_hop_k%0d", k), hopper,
          (k >= 10 && k <= 13) ? 1 : 0);
      chk($sformatf("t4_err_k%0d", k), err, (k == 30) ? 4'b0100 : 4'b0000);
      chk($sformatf("t4_ack_k%0d", k), ack, 0);
      chk($sformatf("t4_busy_k%0d", k), busy, (k <= 30) ? 1 : 0);
      if (k == 30) req = '0;
    end

    // reset during VEND, then pointer restarts at requester 0
    req_goods = '0;
    req_change = '0;
    req_goods[3:2] = 2'd1;
    req = 4'b0010;
    tick;
    tick;
    chk("t6_chute_vend", chute, 3'b001);
    chk("t6_gnt_vend", gnt, 4'b0010);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_chute_async", chute, 0);
    chk("t6_gnt_async", gnt, 0);
    chk("t6_busy_async", busy, 0);
    req = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_ackerr_rst", {ack, err}, 0);
    req_goods = '0;
    req = 4'b1111;
    tick;
    chk("t6_first_gnt", gnt, 4'b0001);
    tick;
    chk("t6_min_ack", ack, 4'b0001);
    req = '0;
    repeat (4) tick;
    chk("t6_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_dispense_arbiter.md
# vend_dispense_arbiter

Shared-mechanism controller sitting behind several vending front-ends. Each front-end raises a request carrying a goods code and a change amount. The block grants one requester at a time in round-robin order. It then sequences the single goods chute motor and the single coin hopper, confirming each ejected coin via a hopper sensor, and returns a completion or fault pulse to the granted requester.

## Interface
Parameters:
- NREQ, 4, number of requesting front-ends (2..8)
- MOTOR_CYC, 8, cycles the chute motor line is held high per vend (≥1)
- COIN_CYC, 4, cycles the hopper line is held high per coin (≥1)
- TIMEOUT, 16, max cycles waited for coin_sense after each hopper pulse (≥1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request level, held until ack/err
- req_goods  in  2*NREQ  goods code of requester i at [2i+1:2i]: 0 none, 1..3 item
- req_change  in  4*NREQ  change coins owed to requester i at [4i+3:4i], 0..15
- coin_sense  in  1  one-cycle pulse per coin leaving the hopper
- gnt  out  NREQ  one-hot, current owner of the mechanism
- ack  out  NREQ  one-cycle pulse, transaction of requester i completed
- err  out  NREQ  one-cycle pulse, requester i's transaction aborted on hopper timeout
- chute  out  3  motor drive, bit g-1 for goods code g
- hopper  out  1  coin eject drive
- busy  out  1  high whenever state ≠ IDLE

## Operation
- All outputs registered. Async reset: state IDLE, gnt/ack/err/chute/hopper/busy = 0, round-robin pointer = NREQ-1 so requester 0 wins first.
- States: IDLE, GRANT, VEND, PAY, SENSE, DONE, FAULT.
- IDLE: if any req bit high, select the first high bit searching upward from pointer+1, wrapping. Go to GRANT, set gnt for the winner, update pointer to the winner. Otherwise stay.
- GRANT: latch the winner's goods code (g) and change (c) into internal registers. Later changes on req_goods/req_change are ignored. Next state: g≠0 → VEND; g=0, c≠0 → PAY; g=0, c=0 → DONE.
- VEND: chute[g-1] high for exactly MOTOR_CYC cycles. Then c≠0 → PAY, else DONE.
- PAY: hopper high for exactly COIN_CYC cycles, then SENSE with the timeout counter cleared.
- SENSE: count cycles.
  - On coin_sense: c ← c-1. If the new c = 0 → DONE, else → PAY.
  - If TIMEOUT cycles pass with no coin_sense → FAULT.
- coin_sense outside SENSE is ignored; at most one coin is credited per SENSE visit.
- DONE: ack[winner] pulses one cycle, gnt cleared, → IDLE.
- FAULT: err[winner] pulses one cycle (no ack), gnt cleared, remaining c discarded, → IDLE.
- Requester dropping req after grant does not abort; the transaction completes and ack/err still pulse.
- Requester dropping req before grant is simply not selected.
- Simultaneous requests: strict round-robin. Each requester is served at most once per rotation while others are waiting.
- Same requester re-raising req in the ack cycle is eligible at the next IDLE, behind other pending requesters.
- Reset mid-operation: chute/hopper drop immediately, no ack/err issued, transaction lost.

## Timing
- IDLE at cycle t with req → GRANT at t+1 (gnt high from t+1) → first action state at t+2.
- Chute, hopper and gnt change only on state edges; no glitches, no overlap of chute and hopper.
- SENSE: coin_sense sampled in cycle k of SENSE (k = 0..TIMEOUT-1) is accepted. No pulse by cycle TIMEOUT-1 → FAULT next cycle.
- Returning to IDLE, one IDLE cycle always separates consecutive grants.
- Minimum transaction (g=0, c=0): GRANT, DONE, so ack at t+2.
- Full transaction length = 2 + MOTOR_CYC·[g≠0] + Σ per coin (COIN_CYC + sense delay + 1) + 1 cycles.

## Test plan
- Reset, then req[0] with g=2, c=0: gnt[0] at t+1; chute=3'b010 for 8 cycles starting t+2; ack[0] at t+10; hopper never high.
- req[1] with g=0, c=2, coin_sense pulsed 2 cycles into each SENSE: two hopper pulses of 4 cycles each; ack[1] only after the second sense.
- req[0..3] all high with g=1, c=0: grants in order 0,1,2,3. Re-raise req[0] during grant 3: order continues 0, not 1.
- req[2] with g=3, c=1, coin_sense never pulsed: chute[2] 8 cycles, hopper 4 cycles, 16 SENSE cycles, err[2] one pulse, no ack[2], busy low next cycle.
- During a transaction, assert coin_sense in PAY and in IDLE: c is not decremented. Change req_change of the granted requester mid-transaction: coin count is unchanged.
- Assert rst while in VEND: chute and gnt go low asynchronously. After release, requester 0 wins first regardless of pre-reset pointer.
